// File: rtl/dot_product_sequencer.sv
// Dot-product job controller: streams VECTOR_WIDTH operand pairs from the vector
// memory, multiply-accumulates them and writes the result to the next result slot.
module dot_product_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int VECTOR_WIDTH    = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int RESULT_WIDTH    = 2*DATA_WIDTH+$clog2(VECTOR_WIDTH),
  parameter int MEM3_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic                       clear,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data_a,
  input  logic [DATA_WIDTH-1:0]      rd_data_b,
  output logic                       res_wr_en,
  output logic [MEM3_ADDR_WIDTH-1:0] res_wr_addr,
  output logic [RESULT_WIDTH-1:0]    res_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       reject,
  output logic                       full,
  output logic [MEM3_ADDR_WIDTH:0]   result_count
);

  localparam int IDX_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int CW    = MEM3_ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(VECTOR_WIDTH-1);
  localparam logic [CW-1:0]    DEPTH = CW'(2**MEM3_ADDR_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [RESULT_WIDTH-1:0]    acc_q, acc_d;
  logic [RESULT_WIDTH-1:0]    hold_q, hold_d;
  logic [MEM3_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       reject_q, reject_d;
  logic                       vld_q;
  logic                       full_w;
  logic [2*DATA_WIDTH-1:0]    prod;

  assign full_w = (cnt_q == DEPTH);
  assign prod   = {{DATA_WIDTH{1'b0}}, rd_data_a} * {{DATA_WIDTH{1'b0}}, rd_data_b};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    // Read data lags the strobe by one cycle, so accumulation rides on vld_q.
    acc_d    = vld_q ? acc_q + RESULT_WIDTH'(prod) : acc_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          ptr_d = '0;
          cnt_d = '0;
        end
        if (start) begin
          if (clear || !full_w) begin
            state_d = S_FETCH;
            addr_d  = base_addr;
            idx_d   = '0;
            acc_d   = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (idx_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        hold_d  = acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = ptr_q + MEM3_ADDR_WIDTH'(1);
        if (cnt_q != DEPTH) cnt_d = cnt_q + CW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      hold_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      vld_q    <= (state_q == S_FETCH);
    end
  end

  assign rd_en        = (state_q == S_FETCH);
  assign rd_addr      = addr_q;
  assign res_wr_en    = (state_q == S_WRITE);
  assign res_wr_addr  = ptr_q;
  assign res_wr_data  = (state_q == S_WRITE) ? acc_q : hold_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign reject       = reject_q;
  assign full         = full_w;
  assign result_count = cnt_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: job-timeline model checked every cycle plus
// directed jobs with hand-computed results.
module tb_dot_product_sequencer;
  localparam int VW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic        clear = 1'b0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data_a = '0;
  logic [7:0]  rd_data_b = '0;
  logic        res_wr_en;
  logic [3:0]  res_wr_addr;
  logic [17:0] res_wr_data;
  logic        busy, done, reject, full;
  logic [4:0]  result_count;

  dot_product_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .busy(busy), .done(done), .reject(reject), .full(full), .result_count(result_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  always @(posedge clk) if (rd_en) begin
    rd_data_a <= mem_a[rd_addr];
    rd_data_b <= mem_b[rd_addr];
  end

  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] dot(input logic [4:0] b);
    logic [17:0] s;
    logic [4:0]  a;
    s = '0;
    for (int i = 0; i < VW; i++) begin
      a = b + 5'(i);
      s = s + 18'(mem_a[a]) * 18'(mem_b[a]);
    end
    return s;
  endfunction

  // Job timeline model: t counts edges since the accepting edge.
  bit          m_active = 0;
  int          m_t = 0;
  logic [4:0]  m_base = '0;
  logic [17:0] m_res = '0;
  logic [3:0]  m_slot = '0;
  logic [3:0]  m_ptr = '0;
  int          m_cnt = 0;
  logic [17:0] m_last_wr = '0;
  logic [4:0]  m_last_rd = '0;
  bit          m_rej = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_t <= 0; m_ptr <= '0; m_cnt <= 0;
      m_last_wr <= '0; m_last_rd <= '0; m_rej <= 0;
    end else begin
      m_rej <= 0;
      if (m_active) begin
        if (m_t < VW) m_last_rd <= m_base + 5'(m_t);
        if (m_t == VW+1) m_last_wr <= m_res;
        if (m_t == VW+2) begin
          m_active <= 0;
          m_ptr <= m_ptr + 4'd1;
          if (m_cnt != 16) m_cnt <= m_cnt + 1;
        end
        m_t <= m_t + 1;
      end else begin
        if (clear) begin m_ptr <= '0; m_cnt <= 0; end
        if (start) begin
          if (clear || m_cnt != 16) begin
            m_active <= 1; m_t <= 0; m_base <= base_addr;
            m_res <= dot(base_addr); m_slot <= clear ? 4'd0 : m_ptr;
          end else m_rej <= 1;
        end
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk) if (chk_on) begin
    bit e_rd, e_wr;
    e_rd = m_active && m_t < VW;
    e_wr = m_active && m_t == VW+1;
    chk("rd_en", rd_en, e_rd);
    chk("rd_addr", rd_addr, e_rd ? 5'(m_base + 5'(m_t)) : m_last_rd);
    chk("busy", busy, m_active && m_t <= VW+1);
    chk("res_wr_en", res_wr_en, e_wr);
    if (e_wr) chk("res_wr_addr", res_wr_addr, m_slot);
    chk("res_wr_data", res_wr_data, e_wr ? m_res : m_last_wr);
    chk("done", done, m_active && m_t == VW+2);
    chk("reject", reject, m_rej);
    chk("result_count", result_count, m_cnt);
    chk("full", full, m_cnt == 16);
  end

  // Capture of DUT write/read activity for the literal checks.
  logic [3:0]  cap_addr;
  logic [17:0] cap_data;
  int          nwr = 0, ndone = 0;
  logic [4:0]  rdq [$];
  always @(negedge clk) begin
    if (res_wr_en) begin cap_addr = res_wr_addr; cap_data = res_wr_data; nwr++; end
    if (done) ndone++;
    if (rd_en) rdq.push_back(rd_addr);
  end

  task automatic kick(input logic [4:0] b, input logic c);
    start = 1'b1; base_addr = b; clear = c;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0; base_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 30);
    chk("job_done", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic set4(input int b, input int a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[5'(b)] = 8'(a0); mem_a[5'(b+1)] = 8'(a1); mem_a[5'(b+2)] = 8'(a2); mem_a[5'(b+3)] = 8'(a3);
    mem_b[5'(b)] = 8'(b0); mem_b[5'(b+1)] = 8'(b1); mem_b[5'(b+2)] = 8'(b2); mem_b[5'(b+3)] = 8'(b3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nw, nd;
    for (int i = 0; i < 32; i++) begin mem_a[i] = 8'(i); mem_b[i] = 8'(i + 1); end
    #2 rst_n = 1'b0;
    chk_on = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_count", result_count, 0);
    chk("reset_busy", busy, 0);

    // Test 1: basic job
    set4(0, 1, 2, 3, 4, 1, 1, 1, 1);
    rdq.delete();
    kick(5'd0, 1'b0);
    wait_done();
    chk("t1_model", m_res, 10);
    chk("t1_data", cap_data, 10);
    chk("t1_addr", cap_addr, 0);
    chk("t1_count", result_count, 1);
    chk("t1_rd0", rdq[0], 0);
    chk("t1_rd3", rdq[3], 3);

    // Test 2: two more jobs
    set4(4, 2, 4, 6, 8, 1, 2, 3, 4);
    kick(5'd4, 1'b0);
    wait_done();
    chk("t2a_data", cap_data, 60);
    chk("t2a_addr", cap_addr, 1);
    set4(8, 0, 5, 0, 3, 2, 0, 4, 1);
    kick(5'd8, 1'b0);
    wait_done();
    chk("t2b_data", cap_data, 3);
    chk("t2b_addr", cap_addr, 2);
    chk("t2_count", result_count, 3);

    // Test 3: address wrap, max operands
    set4(30, 255, 255, 255, 255, 255, 255, 255, 255);
    rdq.delete();
    kick(5'd30, 1'b0);
    wait_done();
    chk("t3_model", m_res, 260100);
    chk("t3_data", cap_data, 260100);
    chk("t3_rd0", rdq[0], 30);
    chk("t3_rd1", rdq[1], 31);
    chk("t3_rd2", rdq[2], 0);
    chk("t3_rd3", rdq[3], 1);

    // Test 6: start/base/clear pokes while busy are ignored
    set4(12, 1, 1, 1, 1, 5, 6, 7, 8);
    kick(5'd12, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'd20; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    wait_done();
    chk("t6_data", cap_data, 26);
    chk("t6_addr", cap_addr, 4);
    chk("t6_count", result_count, 5);

    // Test 4: clear+start together, then fill all 16 slots
    kick(5'd0, 1'b1);
    wait_done();
    chk("t4_first_addr", cap_addr, 0);
    for (int j = 1; j < 16; j++) begin
      kick(5'(j), 1'b0);
      wait_done();
    end
    chk("t4_last_addr", cap_addr, 15);
    chk("t4_count", result_count, 16);
    chk("t4_full", full, 1);
    nw = nwr;
    kick(5'd0, 1'b0);
    @(negedge clk);
    chk("t4_reject", reject, 1);
    chk("t4_rej_busy", busy, 0);
    chk("t4_rej_rden", rd_en, 0);
    repeat (8) @(posedge clk);
    chk("t4_rej_nowr", nwr, nw);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("t4_clr_count", result_count, 0);
    chk("t4_clr_full", full, 0);
    kick(5'd8, 1'b0);
    wait_done();
    chk("t4_post_addr", cap_addr, 0);
    chk("t4_post_data", cap_data, 3);

    // Test 5: reset during FETCH
    nw = nwr; nd = ndone;
    kick(5'd4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rd_en", rd_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", result_count, 0);
    chk("t5_wr_data", res_wr_data, 0);
    chk("t5_rd_addr", rd_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    chk("t5_no_write", nwr, nw);
    chk("t5_no_done", ndone, nd);
    #1;
    kick(5'd4, 1'b0);
    wait_done();
    chk("t5_post_addr", cap_addr, 0);
    chk("t5_post_data", cap_data, 60);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
